// File: rtl/axi_10g_ethernet_0_link_sequencer.sv
// Bring-up and recovery sequencer for the 10G PCS/PMA and MAC: synchronizes raw
// lock/detect status, sequences resets, debounces the link and bounds lock retries.
//
// state        | meaning
// S_RESET      | PCS and MAC held in reset for RESET_HOLD_CYCLES
// S_WAIT_PLL   | both resets held, waiting for QPLL lock (no timeout)
// S_WAIT_BLOCK | PCS released, waiting for debounced block lock + signal detect
// S_LINK_UP    | link usable, both resets released
// S_FAULT      | lock retries exhausted, held until soft reset or aresetn
module axi_10g_ethernet_0_link_sequencer #(
    parameter int C_NUM_SYNC_REGS   = 5,
    parameter int RESET_HOLD_CYCLES = 64,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LOCK_TIMEOUT      = 65536,
    parameter int MAX_RETRIES       = 7
) (
    input  logic       clk,
    input  logic       aresetn,
    input  logic       qplllock_in,
    input  logic       block_lock_in,
    input  logic       signal_detect_in,
    input  logic       soft_reset_req,
    output logic       pcs_reset,
    output logic       mac_reset,
    output logic       link_up,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic [2:0] seq_state
);
    localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES) + 1;
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int TMR_W  = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]        RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET      = 3'd0,
        S_WAIT_PLL   = 3'd1,
        S_WAIT_BLOCK = 3'd2,
        S_LINK_UP    = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [C_NUM_SYNC_REGS-1:0] r_pll_sync;
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [C_NUM_SYNC_REGS-1:0] r_blk_sync;
    (* ASYNC_REG = "TRUE", SHREG_EXTRACT = "NO" *)
    logic [C_NUM_SYNC_REGS-1:0] r_sd_sync;

    state_t            r_state;
    state_t            w_next;
    logic [HOLD_W-1:0] r_hold;
    logic [DEB_W-1:0]  r_deb;
    logic [TMR_W-1:0]  r_timer;
    logic [3:0]        r_retry;
    logic              r_pcs_reset;
    logic              r_mac_reset;
    logic              r_link_up;
    logic              r_fault;
    logic              w_pll_s;
    logic              w_ok_s;
    logic              w_retry_inc;
    logic              w_pcs_reset;
    logic              w_mac_reset;
    logic              w_link_up;
    logic              w_fault;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_pll_sync <= '0;
            r_blk_sync <= '0;
            r_sd_sync  <= '0;
        end else begin
            r_pll_sync <= {r_pll_sync[C_NUM_SYNC_REGS-2:0], qplllock_in};
            r_blk_sync <= {r_blk_sync[C_NUM_SYNC_REGS-2:0], block_lock_in};
            r_sd_sync  <= {r_sd_sync[C_NUM_SYNC_REGS-2:0], signal_detect_in};
        end
    end

    assign w_pll_s = r_pll_sync[C_NUM_SYNC_REGS-1];
    assign w_ok_s  = r_blk_sync[C_NUM_SYNC_REGS-1] & r_sd_sync[C_NUM_SYNC_REGS-1];

    // Outputs are registered from the next-state decode so they move with the state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_RESET;
            r_pcs_reset <= 1'b1;
            r_mac_reset <= 1'b1;
            r_link_up   <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_pcs_reset <= w_pcs_reset;
            r_mac_reset <= w_mac_reset;
            r_link_up   <= w_link_up;
            r_fault     <= w_fault;
        end
    end

    // Priority: soft reset > PLL loss > debounce completion > timeout.
    always_comb begin
        w_next      = r_state;
        w_retry_inc = 1'b0;
        if (soft_reset_req) begin
            w_next = S_RESET;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_hold == HOLD_LAST) w_next = S_WAIT_PLL;
                end
                S_WAIT_PLL: begin
                    if (w_pll_s) w_next = S_WAIT_BLOCK;
                end
                S_WAIT_BLOCK: begin
                    if (!w_pll_s) begin
                        w_next = S_RESET;
                    end else if (w_ok_s && (r_deb == DEB_LAST)) begin
                        w_next = S_LINK_UP;
                    end else if (r_timer == TMR_LAST) begin
                        if (r_retry < RETRY_MAX) begin
                            w_next      = S_RESET;
                            w_retry_inc = 1'b1;
                        end else begin
                            w_next = S_FAULT;
                        end
                    end
                end
                S_LINK_UP: begin
                    if (!w_pll_s) begin
                        w_next = S_RESET;
                    end else if (!w_ok_s && (r_deb == DEB_LAST)) begin
                        w_next = S_WAIT_BLOCK;
                    end
                end
                S_FAULT: begin
                    w_next = S_FAULT;
                end
                default: begin
                    w_next = S_RESET;
                end
            endcase
        end
    end

    always_comb begin
        w_pcs_reset = 1'b1;
        w_mac_reset = 1'b1;
        w_link_up   = 1'b0;
        w_fault     = 1'b0;
        case (w_next)
            S_WAIT_BLOCK: w_pcs_reset = 1'b0;
            S_LINK_UP: begin
                w_pcs_reset = 1'b0;
                w_mac_reset = 1'b0;
                w_link_up   = 1'b1;
            end
            S_FAULT:      w_fault = 1'b1;
            default:      w_pcs_reset = 1'b1;
        endcase
    end

    // Counters restart from zero on every state entry; debounce sense flips with the state.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_hold  <= '0;
            r_deb   <= '0;
            r_timer <= '0;
            r_retry <= '0;
        end else if (soft_reset_req) begin
            r_hold  <= '0;
            r_deb   <= '0;
            r_timer <= '0;
            r_retry <= '0;
        end else begin
            r_hold <= (r_state == S_RESET && w_next == S_RESET) ? r_hold + 1'b1 : '0;
            if (r_state == S_WAIT_BLOCK && w_next == S_WAIT_BLOCK) begin
                r_timer <= r_timer + 1'b1;
                r_deb   <= w_ok_s ? r_deb + 1'b1 : '0;
            end else if (r_state == S_LINK_UP && w_next == S_LINK_UP) begin
                r_timer <= '0;
                r_deb   <= w_ok_s ? '0 : r_deb + 1'b1;
            end else begin
                r_timer <= '0;
                r_deb   <= '0;
            end
            if (w_next == S_LINK_UP && r_state != S_LINK_UP) begin
                r_retry <= '0;
            end else if (w_retry_inc && r_retry != 4'hF) begin
                r_retry <= r_retry + 4'd1;
            end
        end
    end

    assign pcs_reset   = r_pcs_reset;
    assign mac_reset   = r_mac_reset;
    assign link_up     = r_link_up;
    assign fault       = r_fault;
    assign retry_count = r_retry;
    assign seq_state   = r_state;

endmodule

// File: tb/tb_axi_10g_ethernet_0_link_sequencer.sv
// Bench for the link sequencer: expected output snapshots are queued per clock
// cycle as stimulus is applied and compared on the falling edge.
module tb_axi_10g_ethernet_0_link_sequencer;
    localparam int P_SYNC  = 3;
    localparam int P_HOLD  = 4;
    localparam int P_DEB   = 3;
    localparam int P_TMO   = 20;
    localparam int P_RETRY = 2;

    typedef struct {
        int          cyc;
        logic [10:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        qplllock_in = 1'b0;
    logic        block_lock_in = 1'b0;
    logic        signal_detect_in = 1'b0;
    logic        soft_reset_req = 1'b0;
    logic        pcs_reset;
    logic        mac_reset;
    logic        link_up;
    logic        fault;
    logic [3:0]  retry_count;
    logic [2:0]  seq_state;
    logic [10:0] obs;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    exp_t e;

    axi_10g_ethernet_0_link_sequencer #(
        .C_NUM_SYNC_REGS  (P_SYNC),
        .RESET_HOLD_CYCLES(P_HOLD),
        .DEBOUNCE_CYCLES  (P_DEB),
        .LOCK_TIMEOUT     (P_TMO),
        .MAX_RETRIES      (P_RETRY)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .qplllock_in     (qplllock_in),
        .block_lock_in   (block_lock_in),
        .signal_detect_in(signal_detect_in),
        .soft_reset_req  (soft_reset_req),
        .pcs_reset       (pcs_reset),
        .mac_reset       (mac_reset),
        .link_up         (link_up),
        .fault           (fault),
        .retry_count     (retry_count),
        .seq_state       (seq_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign obs = {pcs_reset, mac_reset, link_up, fault, retry_count, seq_state};

    // Output vector implied by a state and retry count: {pcs, mac, link, fault, retry, state}.
    function automatic logic [10:0] ev(input int st, input int rt);
        logic pcs, mac, lnk, flt;
        pcs = (st == 0) || (st == 1) || (st == 4);
        mac = (st != 3);
        lnk = (st == 3);
        flt = (st == 4);
        return {pcs, mac, lnk, flt, 4'(rt), 3'(st)};
    endfunction

    function automatic void push(input int c, input int st, input int rt, input string nm);
        exp_t x;
        int   i;
        x.cyc  = c;
        x.val  = ev(st, rt);
        x.name = nm;
        i = 0;
        while (i < sb_q.size() && sb_q[i].cyc <= c) i++;
        sb_q.insert(i, x);
    endfunction

    task automatic test_reset();
        push(cyc, 0, 0, "reset_values");
        for (int k = 0; k < 8; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 1) begin
                aresetn = 1'b1;
                push(cyc + 3, 0, 0, "hold_last");
                push(cyc + 4, 1, 0, "wait_pll");
                push(cyc + 5, 2, 0, "pcs_release");
            end
            @(negedge clk);
        end
    endtask

    task automatic test_bringup();
        for (int k = 0; k < 10; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 3) begin
                block_lock_in    = 1'b1;
                signal_detect_in = 1'b1;
                push(cyc + 5, 2, 0, "pre_link");
                push(cyc + 6, 3, 0, "link_up");
            end
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        for (int k = 0; k < 21; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 0) begin
                signal_detect_in = 1'b0;
                push(cyc + 4, 3, 0, "glitch_mid");
                push(cyc + 6, 3, 0, "glitch_end");
                push(cyc + 9, 3, 0, "glitch_reject");
            end
            if (k == 2) signal_detect_in = 1'b1;
            if (k == 10) begin
                signal_detect_in = 1'b0;
                push(cyc + 5, 3, 0, "drop_hold");
                push(cyc + 6, 2, 0, "link_drop");
                push(cyc + 8, 2, 0, "relink_wait");
                push(cyc + 9, 3, 0, "relink");
            end
            if (k == 13) signal_detect_in = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_pll_loss();
        for (int k = 0; k < 18; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 0) begin
                qplllock_in = 1'b0;
                push(cyc + 3, 3, 0, "pre_pll_loss");
                push(cyc + 4, 0, 0, "pll_loss");
                push(cyc + 7, 0, 0, "pll_loss_hold");
                push(cyc + 8, 1, 0, "wait_pll_idle");
            end
            if (k == 10) begin
                qplllock_in = 1'b1;
                push(cyc + 3, 1, 0, "wait_pll_no_timeout");
                push(cyc + 4, 2, 0, "pll_relock");
                push(cyc + 7, 3, 0, "relink_after_pll");
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout_fault();
        int e1;
        for (int k = 0; k < 88; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 0) begin
                block_lock_in  = 1'b0;
                soft_reset_req = 1'b1;
                push(cyc + 1, 0, 0, "soft_from_link");
            end
            if (k == 1) begin
                soft_reset_req = 1'b0;
                e1 = cyc + 5;
                push(e1 - 1,  1, 0, "tmo_wait_pll");
                push(e1,      2, 0, "tmo_wait_block");
                push(e1 + 19, 2, 0, "tmo1_pre");
                push(e1 + 20, 0, 1, "retry1");
                push(e1 + 25, 2, 1, "retry1_wait");
                push(e1 + 44, 2, 1, "tmo2_pre");
                push(e1 + 45, 0, 2, "retry2");
                push(e1 + 50, 2, 2, "retry2_wait");
                push(e1 + 69, 2, 2, "tmo3_pre");
                push(e1 + 70, 4, 2, "fault");
                push(e1 + 80, 4, 2, "fault_hold");
            end
            @(negedge clk);
        end
    endtask

    task automatic test_soft_reset();
        for (int k = 0; k < 20; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 0) begin
                soft_reset_req = 1'b1;
                push(cyc + 1, 0, 0, "fault_clear");
                push(cyc + 6, 2, 0, "restart_wait_block");
            end
            if (k == 1) soft_reset_req = 1'b0;
            if (k == 7) begin
                block_lock_in = 1'b1;
                push(cyc + 5, 2, 0, "pre_coincide");
            end
            if (k == 12) begin
                soft_reset_req = 1'b1;
                push(cyc + 1, 0, 0, "soft_beats_link");
                push(cyc + 4, 0, 0, "soft_hold_last");
                push(cyc + 5, 1, 0, "soft_wait_pll");
                push(cyc + 6, 2, 0, "soft_wait_block");
            end
            if (k == 13) begin
                soft_reset_req = 1'b0;
                block_lock_in  = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_async_reset();
        n_tests++;
        if (obs !== ev(2, 0)) begin
            n_fail++;
            $display("FAIL async_pre cyc=%0d: got %b, want %b", cyc, obs, ev(2, 0));
        end
        #2;
        aresetn = 1'b0;
        #1;
        n_tests++;
        if (obs !== ev(0, 0)) begin
            n_fail++;
            $display("FAIL async_reset cyc=%0d: got %b, want %b", cyc, obs, ev(0, 0));
        end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                e = sb_q.pop_front();
                n_tests++;
                if (obs !== e.val) begin
                    n_fail++;
                    $display("FAIL %s cyc=%0d: got %b, want %b", e.name, cyc, obs, e.val);
                end
            end
            if (k == 0) push(cyc, 0, 0, "async_held");
            if (k == 1) begin
                aresetn       = 1'b1;
                block_lock_in = 1'b1;
                push(cyc + 3, 0, 0, "async_hold_last");
                push(cyc + 4, 1, 0, "async_wait_pll");
                push(cyc + 5, 2, 0, "async_wait_block");
                push(cyc + 8, 3, 0, "async_relink");
            end
            @(negedge clk);
        end
    endtask

    initial begin
        qplllock_in = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_bringup();
        test_glitch();
        test_pll_loss();
        test_timeout_fault();
        test_soft_reset();
        test_async_reset();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_10g_ethernet_0_link_sequencer.md
Name: axi_10g_ethernet_0_link_sequencer

Overview:
- Bring-up and recovery controller for the 10G PCS/PMA and MAC.
- Takes raw asynchronous status (QPLL lock, PCS block lock, PMA signal detect) through internal N-stage synchronizers.
- Sequences PCS and MAC resets, debounces link status, enforces a lock timeout with bounded retries, and reports link state.
- Sits in the shared-logic/reset area, clocked by the core's free-running management clock.

Parameters:
- C_NUM_SYNC_REGS, 5, synchronizer depth per status input (min 2).
- RESET_HOLD_CYCLES, 64, cycles both resets are held in S_RESET (min 1).
- DEBOUNCE_CYCLES, 16, consecutive cycles a status condition must persist (min 1).
- LOCK_TIMEOUT, 65536, cycles allowed in S_WAIT_BLOCK before retry (min 2).
- MAX_RETRIES, 7, lock timeouts tolerated before S_FAULT (1..15).

Ports:
- clk, input, 1, free-running management clock.
- aresetn, input, 1, asynchronous active-low reset.
- qplllock_in, input, 1, QPLL lock, asynchronous.
- block_lock_in, input, 1, PCS block lock, asynchronous.
- signal_detect_in, input, 1, PMA signal detect, asynchronous.
- soft_reset_req, input, 1, synchronous one-cycle restart request.
- pcs_reset, output, 1, active-high PCS/PMA reset.
- mac_reset, output, 1, active-high MAC reset.
- link_up, output, 1, link usable.
- fault, output, 1, retries exhausted.
- retry_count, output, 4, lock timeouts since last link-up, saturating.
- seq_state, output, 3, current state encoding.

Behaviour:
- Reset is asynchronous and active-low: aresetn=0 immediately forces the following, regardless of clk.
  - State S_RESET; all counters 0; all synchronizer stages 0.
  - pcs_reset=1, mac_reset=1, link_up=0, fault=0, retry_count=0, seq_state=0.
- Synchronizers: shift-register chain of C_NUM_SYNC_REGS flops per input, no SRL extraction, ASYNC_REG. Synchronized signals are pll_s, blk_s and sd_s; latency is C_NUM_SYNC_REGS cycles.
- ok_s = blk_s & sd_s.
- All outputs are registered and decoded from the next state, so outputs change on the same edge as the state.
- seq_state encoding: S_RESET=0, S_WAIT_PLL=1, S_WAIT_BLOCK=2, S_LINK_UP=3, S_FAULT=4.
- Resets per state:
  - S_RESET and S_WAIT_PLL: pcs_reset=1, mac_reset=1.
  - S_WAIT_BLOCK: pcs_reset=0, mac_reset=1.
  - S_LINK_UP: both 0, link_up=1.
  - S_FAULT: both 1, fault=1.
- S_RESET: hold counter runs from 0. When it reaches RESET_HOLD_CYCLES-1, go to S_WAIT_PLL; the state therefore lasts exactly RESET_HOLD_CYCLES cycles.
- S_WAIT_PLL: when pll_s=1, go to S_WAIT_BLOCK and clear the timer and debounce counters. There is no timeout in this state.
- S_WAIT_BLOCK: the timer increments every cycle.
  - The debounce counter increments while ok_s=1 and clears when ok_s=0.
  - Debounce reaches DEBOUNCE_CYCLES: go to S_LINK_UP and clear retry_count.
  - Otherwise, timer reaches LOCK_TIMEOUT-1:
    - if retry_count < MAX_RETRIES: increment retry_count, go to S_RESET;
    - else go to S_FAULT (retry_count unchanged).
  - pll_s=0: go to S_RESET with no retry increment.
- S_LINK_UP: the debounce counter counts consecutive ok_s=0 cycles and clears when ok_s=1.
  - Reaching DEBOUNCE_CYCLES: go to S_WAIT_BLOCK (timer cleared, mac_reset reasserted, pcs_reset stays 0).
  - pll_s=0: go to S_RESET immediately, with no debounce.
- S_FAULT: terminal. Exit only via soft_reset_req or aresetn.
- soft_reset_req=1 in any state: next state S_RESET, all counters cleared, retry_count=0, fault cleared.
- Priority when events coincide: soft_reset_req > pll loss > debounce completion > timeout. Example: debounce completion and timeout on the same cycle → S_LINK_UP.
- retry_count saturates at 15 and never wraps.
- Counter widths are $clog2 of their parameter +1, so no counter wraps within its limit.
- aresetn asserted mid-sequence: asynchronous return to S_RESET with the reset values above.
- After aresetn deasserts, the hold count restarts from 0.

Test Plan (RESET_HOLD_CYCLES=4, DEBOUNCE_CYCLES=3, LOCK_TIMEOUT=20, MAX_RETRIES=2, C_NUM_SYNC_REGS=3):
- Nominal bring-up: release aresetn with qplllock_in=1, then raise block_lock_in and signal_detect_in at cycle 10 → link_up=1 and mac_reset=0. Must hold:
  - pcs_reset falls 4 cycles after the S_RESET entry, plus 1 cycle in S_WAIT_PLL;
  - link_up rises exactly 3+3 cycles after block_lock_in/signal_detect_in rise;
  - retry_count=0.
- Glitch rejection: in S_LINK_UP, drop signal_detect_in for 2 cycles → link_up stays 1. Drop it for 3 cycles → link_up=0 and mac_reset=1 three cycles after the synchronized drop, with pcs_reset still 0.
- Timeout/retry/fault: keep block_lock_in=0 → retry_count steps 1 then 2, then S_FAULT after the third timeout with fault=1, pcs_reset=1, seq_state=4. Pulse soft_reset_req → fault=0, retry_count=0, seq_state=0.
- PLL loss: in S_LINK_UP, deassert qplllock_in → S_RESET exactly 3+1 cycles later with both resets 1, no debounce delay, and retry_count unchanged.
- Async reset: drop aresetn between clk edges while in S_WAIT_BLOCK → all outputs take reset values before the next clk edge. Release it → the hold sequence restarts from count 0.
- Simultaneous events: in S_WAIT_BLOCK, assert soft_reset_req on the same cycle the debounce completes → S_RESET, not S_LINK_UP.
